// File: rtl/final_result_ctrl_pkg.sv
// Shared types and constants for the final-result controller: state encoding,
// latency counter width and the packing-stage select codes.
package final_result_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_LOAD = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SEL_NORMAL = 2'b00,
    SEL_OVF    = 2'b01,
    SEL_UNF    = 2'b10
  } sel_e;

  // Overflow wins when the datapath raises both flags at once.
  function automatic sel_e sel_encode(input logic ovf, input logic unf);
    sel_e code;
    if (ovf) begin
      code = SEL_OVF;
    end else if (unf) begin
      code = SEL_UNF;
    end else begin
      code = SEL_NORMAL;
    end
    return code;
  endfunction

endpackage

// File: rtl/final_result_ctrl_lat_counter.sv
// Latency down-counter: loadable, decrements while enabled, flags terminal count 1.
module lat_counter
  import final_result_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/final_result_ctrl.sv
// Sequences a floating-point result into the final-result register: waits out the
// datapath latency, captures overflow/underflow, strobes the load and holds ready.
module final_result_ctrl
  import final_result_ctrl_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic flush_i,
  input  logic ovf_i,
  input  logic unf_i,
  input  logic ack_i,
  output logic load_o,
  output logic sel_a_o,
  output logic sel_b_o,
  output logic busy_o,
  output logic ready_o,
  output logic ovf_o,
  output logic unf_o
);

  if (((W != 32) && (W != 64)) || (LAT < 1) || (LAT > 15)) begin : g_param_check
    $error("final_result_ctrl: unsupported W or LAT");
  end

  state_e state_d, state_q;
  sel_e   sel_d, sel_q;
  logic   cnt_clr, cnt_load, cnt_dec, cnt_tc;

  lat_counter u_lat_counter (
    .clk        (clk),
    .rst_n      (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CNT_W'(LAT)),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      sel_d   = SEL_NORMAL;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d  = ST_WAIT;
            sel_d    = SEL_NORMAL;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_d = ST_LOAD;
            sel_d   = sel_encode(ovf_i, unf_i);
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_LOAD: state_d = ST_DONE;
        ST_DONE: begin
          // A start arriving with the ack is dropped; IDLE must be seen first.
          if (ack_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = SEL_NORMAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_NORMAL;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Status flags persist into IDLE; the packing selects only during LOAD/DONE.
  assign load_o  = (state_q == ST_LOAD);
  assign busy_o  = (state_q == ST_WAIT) || (state_q == ST_LOAD);
  assign ready_o = (state_q == ST_DONE);
  assign ovf_o   = (sel_q == SEL_OVF);
  assign unf_o   = (sel_q == SEL_UNF);
  assign sel_a_o = ovf_o && (state_q[1] == 1'b1);
  assign sel_b_o = unf_o && (state_q[1] == 1'b1);

endmodule

// File: tb/tb_final_result_ctrl.sv
// Random-stimulus bench: two controllers (LAT=3 and LAT=1) checked every cycle
// against a cycle-count model of an operation's lifetime.
module tb_final_result_ctrl;

  logic clk, rst;
  logic start_i, flush_i, ovf_i, unf_i, ack_i;
  logic [6:0] obs [2];
  logic load3, sa3, sb3, busy3, rdy3, ov3, un3;
  logic load1, sa1, sb1, busy1, rdy1, ov1, un1;

  int n_checks = 0;
  int n_errors = 0;

  final_result_ctrl #(.W(32), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .ovf_i(ovf_i), .unf_i(unf_i), .ack_i(ack_i),
    .load_o(load3), .sel_a_o(sa3), .sel_b_o(sb3), .busy_o(busy3),
    .ready_o(rdy3), .ovf_o(ov3), .unf_o(un3)
  );

  final_result_ctrl #(.W(64), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .ovf_i(ovf_i), .unf_i(unf_i), .ack_i(ack_i),
    .load_o(load1), .sel_a_o(sa1), .sel_b_o(sb1), .busy_o(busy1),
    .ready_o(rdy1), .ovf_o(ov1), .unf_o(un1)
  );

  assign obs[0] = {load3, sa3, sb3, busy3, rdy3, ov3, un3};
  assign obs[1] = {load1, sa1, sb1, busy1, rdy1, ov1, un1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t = cycles since the accepted start (1 = first cycle after it).
  int lat [2] = '{3, 1};
  bit act [2];
  int t   [2];
  bit fo  [2];
  bit fu  [2];

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (load,sa,sb,busy,rdy,ovf,unf) at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] expect_of(input int i);
    logic ld, rd, bz;
    ld = act[i] && (t[i] == lat[i] + 1);
    bz = act[i] && (t[i] <= lat[i] + 1);
    rd = act[i] && (t[i] >= lat[i] + 2);
    return {ld, (ld || rd) && fo[i], (ld || rd) && fu[i], bz, rd, fo[i], fu[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t[i] = 0; fo[i] = 1'b0; fu[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (flush_i) begin
        act[i] = 1'b0; fo[i] = 1'b0; fu[i] = 1'b0;
      end else if (!act[i]) begin
        if (start_i) begin
          act[i] = 1'b1; t[i] = 1; fo[i] = 1'b0; fu[i] = 1'b0;
        end
      end else if (t[i] <= lat[i]) begin
        if (t[i] == lat[i]) begin
          fo[i] = ovf_i;
          fu[i] = unf_i && !ovf_i;
        end
        t[i]++;
      end else if (t[i] == lat[i] + 1) begin
        t[i]++;
      end else if (ack_i) begin
        act[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_lat3"}, obs[0], expect_of(0));
    check_eq({tag, "_lat1"}, obs[1], expect_of(1));
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    ovf_i = 1'b0; unf_i = 1'b0; ack_i = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #6 rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all("cycle");
      if (cyc < 10) begin
        // Nominal op: start once, quiet flags, ack late.
        start_i = (cyc == 0);
        flush_i = 1'b0; ovf_i = 1'b0; unf_i = 1'b0;
        ack_i   = (cyc == 7);
      end else begin
        start_i = ($urandom_range(0, 1) == 0);
        flush_i = ($urandom_range(0, 24) == 0);
        ovf_i   = ($urandom_range(0, 2) == 0);
        unf_i   = ($urandom_range(0, 2) == 0);
        ack_i   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 149) == 0) begin
          #2 rst = 1'b0;
          #1;
          model_reset();
          check_all("async_rst");
          #1 rst = 1'b1;
        end
      end
      @(posedge clk);
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/final_result_ctrl.md
FINAL_RESULT_CTRL -- requirements
Module: final_result_ctrl

Interface
REQ-001 SHALL have parameter W, default 32: IEEE word width (32 single, 64 double).
REQ-002 SHALL have parameter LAT, default 3: datapath cycles from accepted start to valid ovf_i/unf_i; legal range 1..15.
REQ-003 SHALL have the following ports, in this order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  operation request; honoured only in IDLE.
- flush_i  in  1  synchronous abort.
- ovf_i  in  1  datapath overflow flag.
- unf_i  in  1  datapath underflow flag.
- ack_i  in  1  consumer has taken the result.
- load_o  out  1  final-result register load strobe.
- sel_a_o  out  1  overflow select to the packing stage.
- sel_b_o  out  1  underflow select to the packing stage.
- busy_o  out  1  operation in progress.
- ready_o  out  1  result valid in final-result register.
- ovf_o  out  1  sticky overflow status.
- unf_o  out  1  sticky underflow status.

Function
REQ-004 SHALL implement a four-state machine: IDLE, WAIT, LOAD, DONE.
REQ-005 In IDLE, start_i=1 SHALL load the latency counter with LAT, clear ovf_o/unf_o, and go to WAIT.
REQ-006 WAIT SHALL decrement the counter each cycle; at count 1 it SHALL sample ovf_i/unf_i into the flag registers and go to LOAD.
REQ-007 LOAD SHALL last exactly one cycle with load_o=1, then go to DONE.
REQ-008 DONE SHALL hold ready_o=1 until ack_i=1, then go to IDLE.
REQ-009 Timing: start sampled at edge 0; load_o high in cycle LAT+1; ready_o high from cycle LAT+2.
REQ-010 sel_a_o SHALL equal the registered overflow flag and sel_b_o the registered underflow flag, both held stable through LOAD and DONE and 0 in IDLE/WAIT.
REQ-011 Simultaneous ovf_i=1 and unf_i=1 SHALL register as overflow only; sel_a_o=sel_b_o=1 SHALL never occur.
REQ-012 ovf_o/unf_o SHALL mirror the registered flags and stay valid until the next accepted start.
REQ-013 busy_o SHALL be 1 in WAIT and LOAD, and 0 in IDLE and DONE.
REQ-014 start_i outside IDLE SHALL be ignored; there is no queuing.
REQ-015 ack_i and start_i together in DONE SHALL go to IDLE only; a new start is accepted no earlier than the next cycle.
REQ-016 ack_i outside DONE SHALL be ignored.
REQ-017 flush_i=1 in any state SHALL force IDLE next cycle, suppress load_o, and clear the sel outputs and flags; flush_i has priority over start_i and ack_i.
REQ-018 All outputs SHALL be registered or decoded from state registers only, with no combinational path from inputs.

Reset
REQ-019 rst=0 SHALL immediately force IDLE, counter=0, and load_o, sel_a_o, sel_b_o, busy_o, ready_o, ovf_o, unf_o all 0.
REQ-020 Reset asserted mid-operation SHALL abort without a load_o pulse.
REQ-021 After rst rises, the first start_i SHALL be accepted on the first clock edge.

Structure
REQ-022 A shared package SHALL hold the state encoding (IDLE=2'b00, WAIT=2'b01, LOAD=2'b10, DONE=2'b11).
REQ-023 The same package SHALL hold the 4-bit counter width constant and the sel codes NORMAL, OVF, UNF.
REQ-024 The latency down-counter SHALL be one sub-module, lat_counter (load, decrement, terminal-count output); the FSM stays in final_result_ctrl.

Verification
REQ-025 Nominal, LAT=3, ovf_i=unf_i=0 -> load_o high only in cycle 4, ready_o from cycle 5, sel_a_o=sel_b_o=0.
REQ-026 ovf_i=1 and unf_i=1 at cycle 3 -> sel_a_o=1, sel_b_o=0, ovf_o=1, unf_o=0 from cycle 4 through DONE.
REQ-027 unf_i=1 at cycle 3, ack_i at cycle 7 -> sel_b_o=1 in cycles 4..7, IDLE in cycle 8, unf_o still 1.
REQ-028 start_i repeated in cycles 1..6 -> single load_o pulse; ack_i plus start_i in the same DONE cycle -> IDLE, then a new op accepted on the following start.
REQ-029 flush_i at cycle 2, or rst=0 at cycle 3 -> no load_o pulse, all outputs 0, and the next start runs a normal op.
REQ-030 LAT=1 corner -> load_o in cycle 2, ready_o from cycle 3.
